// File: rtl/muldiv_wb_arbiter_pkg.sv
// Shared types and helpers for the MULT unit writeback arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package muldiv_wb_arbiter_pkg;

  // Transaction id width shared with the scoreboard in the core.
  localparam int TRANS_ID_BITS = 3;
  // Native datapath width and the width of RV64 *W results.
  localparam int XLEN     = 64;
  localparam int WORD_LEN = 32;

  // Sign-extend the low word_w bits of val over the full XLEN.
  // Reusable by any writeback path that handles *W results.
  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] val,
                                                input int              word_w);
    logic [XLEN-1:0] hi_mask;
    logic [XLEN-1:0] shifted;
    hi_mask = {XLEN{1'b1}} << word_w;
    shifted = val >> (word_w - 1);
    return shifted[0] ? (val | hi_mask) : (val & ~hi_mask);
  endfunction

endpackage

// File: rtl/muldiv_wb_arbiter_if.sv
// Result streams from multiplier/divider plus the merged writeback port.
// Latency: n/a (bundle of wires).
// Backpressure: only the divider stream has a ready; multiplier cannot stall.
interface muldiv_wb_arbiter_if
  import muldiv_wb_arbiter_pkg::*;
#(
  parameter int WIDTH = XLEN
) ();

  // multiplier stream
  logic                     mul_valid_i;
  logic [TRANS_ID_BITS-1:0] mul_trans_id_i;
  logic [WIDTH-1:0]         mul_result_i;
  // divider issue tracking and result stream
  logic                     div_issue_i;
  logic                     div_word_op_i;
  logic                     div_vld_i;
  logic                     div_rdy_o;
  logic [TRANS_ID_BITS-1:0] div_id_i;
  logic [WIDTH-1:0]         div_res_i;
  logic                     div_busy_o;
  // merged writeback
  logic                     valid_o;
  logic [TRANS_ID_BITS-1:0] trans_id_o;
  logic [WIDTH-1:0]         result_o;

  // arbiter side
  modport slave (
    input  mul_valid_i, mul_trans_id_i, mul_result_i,
    input  div_issue_i, div_word_op_i, div_vld_i, div_id_i, div_res_i,
    output div_rdy_o, div_busy_o,
    output valid_o, trans_id_o, result_o
  );

  // producer / consumer side
  modport master (
    output mul_valid_i, mul_trans_id_i, mul_result_i,
    output div_issue_i, div_word_op_i, div_vld_i, div_id_i, div_res_i,
    input  div_rdy_o, div_busy_o,
    input  valid_o, trans_id_o, result_o
  );

endinterface

// File: rtl/muldiv_wb_arbiter.sv
// Merges multiplier and divider results onto one registered writeback port.
// Latency: 1 cycle input to writeback; a colliding divide result waits in a 1-entry hold.
// Backpressure: multiplier always wins; divider is accepted whenever a divide is in flight.
module muldiv_wb_arbiter
  import muldiv_wb_arbiter_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int WORD_W = WORD_LEN
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  muldiv_wb_arbiter_if.slave     wb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                   state_q,    state_d;
  logic                     word_q,     word_d;
  logic [TRANS_ID_BITS-1:0] hold_id_q,  hold_id_d;
  logic [WIDTH-1:0]         hold_res_q, hold_res_d;
  logic                     valid_q,    valid_d;
  logic [TRANS_ID_BITS-1:0] trans_id_q, trans_id_d;
  logic [WIDTH-1:0]         result_q,   result_d;

  // Divide result after optional *W extension; extension happens before the
  // hold register so the drain path needs no further fix-up.
  logic [XLEN-1:0]  div_sext;
  logic [WIDTH-1:0] div_res_ext;
  assign div_sext    = sext_word(XLEN'(wb.div_res_i), WORD_W);
  assign div_res_ext = word_q ? div_sext[WIDTH-1:0] : wb.div_res_i;

  // Next-state, hold capture and writeback priority mux.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    hold_id_d  = hold_id_q;
    hold_res_d = hold_res_q;
    valid_d    = 1'b0;
    trans_id_d = trans_id_q;
    result_d   = result_q;

    if (flush_i) begin
      // Everything in flight this cycle is dropped; divider flushes alongside.
      state_d    = IDLE;
      word_d     = 1'b0;
      hold_id_d  = '0;
      hold_res_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wb.div_issue_i) begin
            state_d = BUSY;
            word_d  = wb.div_word_op_i;
          end
        end
        BUSY: begin
          if (wb.div_vld_i) begin
            if (wb.mul_valid_i) begin
              hold_id_d  = wb.div_id_i;
              hold_res_d = div_res_ext;
              state_d    = HOLD;
            end else begin
              state_d = IDLE;
            end
          end
        end
        HOLD: begin
          // Back-to-back multiplier results may starve the drain; intended.
          if (!wb.mul_valid_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (wb.mul_valid_i) begin
        valid_d    = 1'b1;
        trans_id_d = wb.mul_trans_id_i;
        result_d   = wb.mul_result_i;
      end else if (state_q == HOLD) begin
        valid_d    = 1'b1;
        trans_id_d = hold_id_q;
        result_d   = hold_res_q;
      end else if (state_q == BUSY && wb.div_vld_i) begin
        valid_d    = 1'b1;
        trans_id_d = wb.div_id_i;
        result_d   = div_res_ext;
      end
    end
  end

  // State, hold buffer and writeback registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      word_q     <= 1'b0;
      hold_id_q  <= '0;
      hold_res_q <= '0;
      valid_q    <= 1'b0;
      trans_id_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      hold_id_q  <= hold_id_d;
      hold_res_q <= hold_res_d;
      valid_q    <= valid_d;
      trans_id_q <= trans_id_d;
      result_q   <= result_d;
    end
  end

  assign wb.div_rdy_o  = (state_q == BUSY);
  assign wb.div_busy_o = (state_q != IDLE);
  assign wb.valid_o    = valid_q;
  assign wb.trans_id_o = trans_id_q;
  assign wb.result_o   = result_q;

  // Issue must hold off new divides while one is in flight or held.
  a_no_issue_when_busy : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(wb.div_issue_i && state_q != IDLE)
  );

endmodule

// File: tb/tb_muldiv_wb_arbiter.sv
// Directed bench for the MULT writeback arbiter.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: exercises multiplier priority, hold starvation and flush.
module tb_muldiv_wb_arbiter;
  import muldiv_wb_arbiter_pkg::*;

  logic clk_i;
  logic rst_ni;
  logic flush_i;
  int   errors;
  int   checks;

  muldiv_wb_arbiter_if #(.WIDTH(64)) wb ();

  muldiv_wb_arbiter #(.WIDTH(64), .WORD_W(32)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .wb      (wb)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i           = 1'b0;
    wb.mul_valid_i    = 1'b0;
    wb.mul_trans_id_i = '0;
    wb.mul_result_i   = '0;
    wb.div_issue_i    = 1'b0;
    wb.div_word_op_i  = 1'b0;
    wb.div_vld_i      = 1'b0;
    wb.div_id_i       = '0;
    wb.div_res_i      = '0;
  endtask

  task automatic issue(input logic word);
    wb.div_issue_i   = 1'b1;
    wb.div_word_op_i = word;
    tick();
    wb.div_issue_i   = 1'b0;
    wb.div_word_op_i = 1'b0;
  endtask

  task automatic set_mul(input logic [2:0] id, input logic [63:0] res);
    wb.mul_valid_i    = 1'b1;
    wb.mul_trans_id_i = id;
    wb.mul_result_i   = res;
  endtask

  task automatic set_div(input logic [2:0] id, input logic [63:0] res);
    wb.div_vld_i = 1'b1;
    wb.div_id_i  = id;
    wb.div_res_i = res;
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic [2:0] id, input logic [63:0] res);
    chk({tag, ".valid"}, 64'(wb.valid_o), 64'(v));
    chk({tag, ".id"},    64'(wb.trans_id_o), 64'(id));
    chk({tag, ".res"},   wb.result_o, res);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle_inputs();
    rst_ni = 1'b0;
    #12;
    // reset state
    chk_wb("reset", 1'b0, 3'd0, 64'h0);
    chk("reset.rdy",  64'(wb.div_rdy_o),  64'h0);
    chk("reset.busy", 64'(wb.div_busy_o), 64'h0);
    rst_ni = 1'b1;
    tick();

    // divide without contention, result 5 cycles after issue
    issue(1'b0);
    chk("div.busy", 64'(wb.div_busy_o), 64'h1);
    chk("div.rdy",  64'(wb.div_rdy_o),  64'h1);
    for (int i = 0; i < 4; i++) tick();
    set_div(3'd3, 64'h7);
    tick();
    idle_inputs();
    chk_wb("div", 1'b1, 3'd3, 64'h7);
    chk("div.busy_after", 64'(wb.div_busy_o), 64'h0);
    chk("div.rdy_after",  64'(wb.div_rdy_o),  64'h0);
    tick();
    chk_wb("div.idle", 1'b0, 3'd3, 64'h7);

    // collision: multiplier first, held divide next cycle
    issue(1'b0);
    set_div(3'd2, 64'h5);
    set_mul(3'd6, 64'h30);
    tick();
    idle_inputs();
    chk_wb("coll.mul", 1'b1, 3'd6, 64'h30);
    chk("coll.busy_hold", 64'(wb.div_busy_o), 64'h1);
    chk("coll.rdy_hold",  64'(wb.div_rdy_o),  64'h0);
    tick();
    chk_wb("coll.div", 1'b1, 3'd2, 64'h5);
    chk("coll.busy_done", 64'(wb.div_busy_o), 64'h0);

    // starved hold: 4 further multiplier results delay the drain
    issue(1'b0);
    set_div(3'd1, 64'h11);
    set_mul(3'd7, 64'h70);
    tick();
    chk_wb("starve.m0", 1'b1, 3'd7, 64'h70);
    for (int k = 0; k < 4; k++) begin
      set_mul(3'(k + 2), 64'h200 + 64'(k));
      tick();
      chk_wb($sformatf("starve.m%0d", k + 1), 1'b1, 3'(k + 2), 64'h200 + 64'(k));
      chk($sformatf("starve.busy%0d", k + 1), 64'(wb.div_busy_o), 64'h1);
    end
    idle_inputs();
    tick();
    chk_wb("starve.div", 1'b1, 3'd1, 64'h11);
    chk("starve.busy_done", 64'(wb.div_busy_o), 64'h0);

    // word op: negative word sign-extends
    issue(1'b1);
    set_div(3'd5, 64'h0000_0000_8000_0000);
    tick();
    idle_inputs();
    chk_wb("word.neg", 1'b1, 3'd5, 64'hFFFF_FFFF_8000_0000);
    // same input, non-word op passes unchanged
    issue(1'b0);
    set_div(3'd5, 64'h0000_0000_8000_0000);
    tick();
    idle_inputs();
    chk_wb("word.off", 1'b1, 3'd5, 64'h0000_0000_8000_0000);
    // positive word clears upper garbage
    issue(1'b1);
    set_div(3'd4, 64'hFFFF_FFFF_7FFF_FFFF);
    tick();
    idle_inputs();
    chk_wb("word.pos", 1'b1, 3'd4, 64'h0000_0000_7FFF_FFFF);
    // word op through the hold path; multiplier result is not extended
    issue(1'b1);
    set_div(3'd1, 64'h0000_0000_F000_0001);
    set_mul(3'd2, 64'h0000_0000_8000_0000);
    tick();
    idle_inputs();
    chk_wb("word.mul", 1'b1, 3'd2, 64'h0000_0000_8000_0000);
    tick();
    chk_wb("word.hold", 1'b1, 3'd1, 64'hFFFF_FFFF_F000_0001);

    // flush in HOLD: held result is dropped, mul in flush cycle discarded
    issue(1'b0);
    set_div(3'd3, 64'h33);
    set_mul(3'd4, 64'h44);
    tick();
    idle_inputs();
    chk("flush.busy_pre", 64'(wb.div_busy_o), 64'h1);
    flush_i = 1'b1;
    set_mul(3'd5, 64'h55);
    tick();
    idle_inputs();
    chk_wb("flush", 1'b0, 3'd4, 64'h44);
    chk("flush.busy", 64'(wb.div_busy_o), 64'h0);
    tick();
    chk("flush.no_drain1", 64'(wb.valid_o), 64'h0);
    tick();
    chk("flush.no_drain2", 64'(wb.valid_o), 64'h0);

    // flush in BUSY keeps div_rdy_o high that cycle
    issue(1'b0);
    flush_i = 1'b1;
    set_div(3'd6, 64'h66);
    #1;
    chk("flushb.rdy", 64'(wb.div_rdy_o), 64'h1);
    tick();
    idle_inputs();
    chk("flushb.valid", 64'(wb.valid_o), 64'h0);
    chk("flushb.busy",  64'(wb.div_busy_o), 64'h0);

    // simultaneous issue and flush: flush wins
    wb.div_issue_i = 1'b1;
    flush_i        = 1'b1;
    tick();
    idle_inputs();
    chk("issflush.busy", 64'(wb.div_busy_o), 64'h0);

    // async reset while BUSY with a nonzero writeback register
    set_mul(3'd7, 64'hABCD);
    tick();
    idle_inputs();
    issue(1'b0);
    chk("rst.busy_pre", 64'(wb.div_busy_o), 64'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_wb("rst.mid", 1'b0, 3'd0, 64'h0);
    chk("rst.rdy",  64'(wb.div_rdy_o),  64'h0);
    chk("rst.busy", 64'(wb.div_busy_o), 64'h0);
    #2;
    rst_ni = 1'b1;
    tick();
    chk("rst.no_emit", 64'(wb.valid_o), 64'h0);
    issue(1'b0);
    chk("rst.reissue_busy", 64'(wb.div_busy_o), 64'h1);
    set_div(3'd6, 64'h9);
    tick();
    idle_inputs();
    chk_wb("rst.div", 1'b1, 3'd6, 64'h9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_wb_arbiter.md
Name: muldiv_wb_arbiter

Overview:
- Writeback stage directly downstream of the serial divider and the pipelined multiplier in the MULT functional unit.
- Merges both result streams onto one registered writeback port. The multiplier always has priority because its fixed-latency pipeline cannot stall.
- Divider results are captured into a one-entry holding register and drained in the first free slot. The unit also tracks the in-flight divide, applies RV64 *W sign extension to divide results, and reports divider occupancy to issue.

Parameters:
- WIDTH, 64, datapath width of both result streams.
- WORD_W, 32, width of the word-op result that is sign-extended to WIDTH.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush
- mul_valid_i  in  1  multiplier result valid; no backpressure
- mul_trans_id_i  in  TRANS_ID_BITS  multiplier transaction id
- mul_result_i  in  WIDTH  multiplier result
- div_issue_i  in  1  a divide op was handed to the divider this cycle
- div_word_op_i  in  1  the issued divide is a *W op; sampled with div_issue_i
- div_vld_i  in  1  divider result valid
- div_rdy_o  out  1  arbiter accepts the divider result
- div_id_i  in  TRANS_ID_BITS  divider transaction id
- div_res_i  in  WIDTH  divider result
- div_busy_o  out  1  divide in flight or held; issue must not send a new divide
- valid_o  out  1  writeback valid
- trans_id_o  out  TRANS_ID_BITS  writeback transaction id
- result_o  out  WIDTH  writeback data

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: state IDLE; valid_o=0, trans_id_o=0, result_o=0, div_rdy_o=0, div_busy_o=0; hold register and word flag 0.
- Output register: valid_o, trans_id_o and result_o are flopped, so latency from input to writeback is exactly 1 cycle.
- Per-cycle priority into the output register:
  - mul_valid_i → multiplier result.
  - else HOLD → held divide result.
  - else BUSY with div_vld_i → divide result, bypassing the hold register.
  - else valid_o=0 next cycle; data registers keep their value.
- FSM states are IDLE, BUSY and HOLD.
  - IDLE→BUSY on div_issue_i. Sample div_word_op_i into word_q.
  - BUSY with div_vld_i and no mul_valid_i → write the result to the output register, go to IDLE.
  - BUSY with div_vld_i and mul_valid_i → capture id and result into the hold register, go to HOLD.
  - HOLD with no mul_valid_i → drain the hold register to the output, go to IDLE.
  - HOLD with mul_valid_i → stay in HOLD. Consecutive multiplier results may delay the drain indefinitely; this is by design.
- div_rdy_o = (state==BUSY). Combinational, so a divider result is always accepted the cycle it is presented in BUSY.
- div_busy_o = (state!=IDLE).
- div_issue_i outside IDLE is a protocol violation. The arbiter ignores it, and an assertion flags it in simulation.
- Sign extension: when word_q=1, the divide result is replaced by WORD_W-bit bit[WORD_W-1] replicated over [WIDTH-1:WORD_W] before capture or bypass. Multiplier results pass unmodified.
- Flush:
  - flush_i forces state to IDLE, clears the hold register and word_q, and sets valid_o=0 next cycle.
  - mul_valid_i or div_vld_i in a flush cycle is discarded.
  - div_rdy_o stays combinationally high in BUSY during the flush cycle; the divider is flushed in the same cycle.
- Simultaneous div_issue_i and flush_i: flush wins, state stays IDLE.
- Reset mid-operation: all state returns to reset values immediately. No result is emitted.

Decomposition:
- TRANS_ID_BITS comes from the shared core package.
- The FSM state enum (IDLE, BUSY, HOLD) is local to this block.
- The sign-extension helper is a package function, sext_word, so other writeback paths can reuse it.
- No sub-module is required. The hold register is a plain one-entry buffer inside the block.

Test Plan:
- Divide, no contention: div_issue_i (word=0), 5 cycles later div_vld_i, id=3, res=64'h7 → next cycle valid_o=1, trans_id_o=3, result_o=64'h7; div_busy_o low.
- Collision: div_vld_i (id=2, res=64'h5) together with mul_valid_i (id=6, res=64'h30) → cycle+1 outputs id 6; cycle+2 outputs id 2, res 64'h5; state passes through HOLD.
- Starved hold: hold occupied plus 4 consecutive mul_valid_i → 4 multiplier writebacks in order, then the divide result; div_busy_o high throughout.
- Word op: div_word_op_i=1, div_res_i=64'h0000_0000_8000_0000 → result_o=64'hFFFF_FFFF_8000_0000. With word=0 the same input passes unchanged.
- Flush in HOLD: flush_i asserted → valid_o=0 next cycle, div_busy_o=0, and the held result is never emitted.
- Async reset asserted in BUSY → all outputs 0 immediately. After release, a new div_issue_i is accepted.
